// File: rtl/axis_packet_master_pkg.sv
// Shared types and default widths for the AXI-Stream packet master, slave and checker blocks.
package axis_pkt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int DEF_DATA_W     = 32;
  localparam int DEF_LEN_W      = 8;
  localparam int DEF_CNT_W      = 16;
  localparam int DEF_GAP_CYCLES = 4;

endpackage

// File: rtl/axis_packet_master_if.sv
// AXI4-Stream data channel bundle; master drives data/valid/last, slave drives ready.
interface axis_packet_master_if #(
  parameter int DATA_W = axis_pkt_pkg::DEF_DATA_W
) ();
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_packet_master.sv
// AXI4-Stream master emitting one incrementing-data packet per accepted start command.
// Optional inter-packet idle gap enabled by defining AXIS_PKT_GAP_EN.
module axis_packet_master
  import axis_pkt_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int LEN_W      = DEF_LEN_W,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LEN_W-1:0]     start_len,
  input  logic [DATA_W-1:0]    seed,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     pkt_count,
  axis_packet_master_if.master m_axis
);

  state_t             state, state_n;
  logic [DATA_W-1:0]  tdata_q;
  logic               tvalid_q, tlast_q;
  logic [LEN_W-1:0]   len_q, beat_q;
  logic               accept, xfer;

`ifdef AXIS_PKT_GAP_EN
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  logic [GAP_W-1:0]   gap_q;
  logic               gap_end;
  assign gap_end = (gap_q == GAP_W'(GAP_CYCLES - 1));
`endif

  assign m_axis.tdata  = tdata_q;
  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tlast  = tlast_q;
  assign busy          = (state != IDLE);

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    xfer    = tvalid_q && m_axis.tready;
    case (state)
      IDLE: begin
        accept = start && (start_len != '0);
        if (accept) state_n = SEND;
      end
      SEND: begin
        if (xfer && tlast_q) begin
`ifdef AXIS_PKT_GAP_EN
          state_n = GAP;
`else
          state_n = IDLE;
`endif
        end
      end
`ifdef AXIS_PKT_GAP_EN
      GAP:     if (gap_end) state_n = IDLE;
`endif
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tdata_q   <= '0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      done      <= 1'b0;
      pkt_count <= '0;
      len_q     <= '0;
      beat_q    <= '0;
`ifdef AXIS_PKT_GAP_EN
      gap_q     <= '0;
`endif
    end else begin
      state <= state_n;
      done  <= 1'b0;
      if (accept) begin
        len_q    <= start_len;
        beat_q   <= '0;
        tdata_q  <= seed;
        tvalid_q <= 1'b1;
        tlast_q  <= (start_len == LEN_W'(1));
      end else if (xfer) begin
        if (tlast_q) begin
          tvalid_q  <= 1'b0;
          tlast_q   <= 1'b0;
          pkt_count <= pkt_count + CNT_W'(1);
`ifndef AXIS_PKT_GAP_EN
          done      <= 1'b1;
`endif
        end else begin
          beat_q  <= beat_q + LEN_W'(1);
          tdata_q <= tdata_q + DATA_W'(1);
          // next beat index is beat_q+1; it is last when beat_q+2 == len
          tlast_q <= (beat_q + LEN_W'(2) == len_q);
        end
      end
`ifdef AXIS_PKT_GAP_EN
      gap_q <= (state == GAP) ? gap_q + GAP_W'(1) : '0;
      if (state == GAP && gap_end) done <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_axis_packet_master.sv
// Directed self-checking bench for axis_packet_master (default widths, 32-bit data).
module tb_axis_packet_master;
  import axis_pkt_pkg::*;

  localparam int DATA_W = 32;
  localparam int LEN_W  = 8;
  localparam int CNT_W  = 16;
  localparam int GAPC   = 4;

  logic              clk = 1'b0;
  logic              rst, start, busy, done;
  logic [LEN_W-1:0]  start_len;
  logic [DATA_W-1:0] seed;
  logic [CNT_W-1:0]  pkt_count;

  axis_packet_master_if #(.DATA_W(DATA_W)) ax ();

  axis_packet_master #(.DATA_W(DATA_W), .LEN_W(LEN_W), .CNT_W(CNT_W), .GAP_CYCLES(GAPC)) dut (
    .clk(clk), .rst(rst), .start(start), .start_len(start_len), .seed(seed),
    .busy(busy), .done(done), .pkt_count(pkt_count), .m_axis(ax.master)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc_n = 0;
  int done_n = 0;
  int done_c = 0;
  logic [DATA_W-1:0] cap_d[$];
  logic              cap_l[$];
  int                cap_c[$];
  logic              prev_v = 1'b0, prev_x = 1'b0, prev_l = 1'b0, prev_rst = 1'b1;
  logic [DATA_W-1:0] prev_d = '0;

  // Mid-cycle monitor: records transfers/done and checks that a stalled beat holds.
  always @(negedge clk) begin
    cyc_n++;
    if (!prev_rst && prev_v && !prev_x) begin
      total++;
      if (ax.tvalid !== 1'b1 || ax.tdata !== prev_d || ax.tlast !== prev_l) begin
        bad++;
        $display("FAIL hold: got v=%b d=%h l=%b want v=1 d=%h l=%b", ax.tvalid, ax.tdata, ax.tlast, prev_d, prev_l);
      end
    end
    prev_v   = ax.tvalid;
    prev_x   = ax.tvalid && ax.tready;
    prev_d   = ax.tdata;
    prev_l   = ax.tlast;
    prev_rst = rst;
    if (!rst && ax.tvalid && ax.tready) begin
      cap_d.push_back(ax.tdata);
      cap_l.push_back(ax.tlast);
      cap_c.push_back(cyc_n);
    end
    if (!rst && done) begin
      done_n++;
      done_c = cyc_n;
    end
  end

  task automatic wait_cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_cap();
    cap_d.delete(); cap_l.delete(); cap_c.delete();
    done_n = 0;
  endtask

  task automatic kick(input logic [LEN_W-1:0] len, input logic [DATA_W-1:0] sd);
    @(posedge clk); #1;
    start = 1'b1; start_len = len; seed = sd;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; start_len = '0; seed = '0; ax.tready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (ax.tvalid !== 1'b0 || ax.tlast !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctl: got v=%b l=%b busy=%b done=%b want all 0", ax.tvalid, ax.tlast, busy, done);
    end
    total++;
    if (ax.tdata !== '0 || pkt_count !== '0) begin
      bad++;
      $display("FAIL reset_data: got tdata=%h cnt=%0d want 0 0", ax.tdata, pkt_count);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [DATA_W-1:0] exp_d[4];
    exp_d = '{32'h10, 32'h11, 32'h12, 32'h13};
    clear_cap();
    ax.tready = 1'b1;
    kick(4, 32'h10);
    @(negedge clk);
    total++;
    if (ax.tvalid !== 1'b1 || ax.tdata !== 32'h10 || busy !== 1'b1) begin
      bad++;
      $display("FAIL basic_latency: got v=%b d=%h busy=%b want 1 10 1", ax.tvalid, ax.tdata, busy);
    end
    wait_cyc(8);
    total++;
    if (cap_d.size() != 4) begin
      bad++;
      $display("FAIL basic_count: got %0d beats want 4", cap_d.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (cap_d[i] !== exp_d[i] || cap_l[i] !== (i == 3)) begin
          bad++;
          $display("FAIL basic_beat%0d: got d=%h l=%b want d=%h l=%b", i, cap_d[i], cap_l[i], exp_d[i], (i == 3));
        end
      end
      total++;
      if (cap_c[3] - cap_c[0] != 3 || done_c != cap_c[3] + 1) begin
        bad++;
        $display("FAIL basic_timing: got span=%0d done_off=%0d want 3 1", cap_c[3] - cap_c[0], done_c - cap_c[3]);
      end
    end
    total++;
    if (done_n != 1 || pkt_count !== 16'd1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL basic_done: got done=%0d cnt=%0d busy=%b want 1 1 0", done_n, pkt_count, busy);
    end
  endtask

  task automatic test_backpressure();
    logic pat[6];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    clear_cap();
    ax.tready = 1'b0;
    kick(3, 32'hA0);
    ax.tready = pat[0];
    for (int i = 1; i < 6; i++) begin
      @(posedge clk); #1;
      ax.tready = pat[i];
    end
    @(posedge clk); #1;
    ax.tready = 1'b1;
    wait_cyc(4);
    total++;
    if (cap_d.size() != 3) begin
      bad++;
      $display("FAIL bp_count: got %0d transfers want 3", cap_d.size());
    end else begin
      total++;
      if (cap_d[0] !== 32'hA0 || cap_d[1] !== 32'hA1 || cap_d[2] !== 32'hA2) begin
        bad++;
        $display("FAIL bp_data: got %h %h %h want a0 a1 a2", cap_d[0], cap_d[1], cap_d[2]);
      end
      total++;
      if (cap_l[0] !== 1'b0 || cap_l[1] !== 1'b0 || cap_l[2] !== 1'b1) begin
        bad++;
        $display("FAIL bp_last: got %b%b%b want 001", cap_l[0], cap_l[1], cap_l[2]);
      end
      total++;
      if (cap_c[1] - cap_c[0] != 3 || cap_c[2] - cap_c[1] != 2) begin
        bad++;
        $display("FAIL bp_spacing: got %0d %0d want 3 2", cap_c[1] - cap_c[0], cap_c[2] - cap_c[1]);
      end
    end
    total++;
    if (done_n != 1 || pkt_count !== 16'd2) begin
      bad++;
      $display("FAIL bp_done: got done=%0d cnt=%0d want 1 2", done_n, pkt_count);
    end
  endtask

  task automatic test_wrap();
    clear_cap();
    ax.tready = 1'b1;
    kick(1, 32'hFFFF_FFFF);
    wait_cyc(3);
    total++;
    if (cap_d.size() != 1 || cap_d[0] !== 32'hFFFF_FFFF || cap_l[0] !== 1'b1) begin
      bad++;
      $display("FAIL len1: got n=%0d d=%h l=%b want 1 ffffffff 1", cap_d.size(),
               (cap_d.size() > 0) ? cap_d[0] : 32'h0, (cap_l.size() > 0) ? cap_l[0] : 1'b0);
    end
    clear_cap();
    kick(2, 32'hFFFF_FFFF);
    wait_cyc(4);
    total++;
    if (cap_d.size() != 2) begin
      bad++;
      $display("FAIL wrap_count: got %0d want 2", cap_d.size());
    end else begin
      total++;
      if (cap_d[0] !== 32'hFFFF_FFFF || cap_d[1] !== 32'h0 || cap_l[0] !== 1'b0 || cap_l[1] !== 1'b1) begin
        bad++;
        $display("FAIL wrap_data: got %h/%b %h/%b want ffffffff/0 00000000/1", cap_d[0], cap_l[0], cap_d[1], cap_l[1]);
      end
    end
    total++;
    if (pkt_count !== 16'd4) begin
      bad++;
      $display("FAIL wrap_cnt: got %0d want 4", pkt_count);
    end
  endtask

  task automatic test_ignore();
    clear_cap();
    ax.tready = 1'b1;
    kick(0, 32'h55);
    wait_cyc(4);
    total++;
    if (cap_d.size() != 0 || done_n != 0 || pkt_count !== 16'd4 || busy !== 1'b0) begin
      bad++;
      $display("FAIL len0: got beats=%0d done=%0d cnt=%0d busy=%b want 0 0 4 0", cap_d.size(), done_n, pkt_count, busy);
    end
    kick(5, 32'h30);
    start = 1'b1; start_len = 8'd2; seed = 32'h99;
    @(posedge clk); #1;
    start = 1'b0;
    wait_cyc(10);
    total++;
    if (cap_d.size() != 5) begin
      bad++;
      $display("FAIL busy_ign_count: got %0d beats want 5", cap_d.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        total++;
        if (cap_d[i] !== 32'h30 + i) begin
          bad++;
          $display("FAIL busy_ign_beat%0d: got %h want %h", i, cap_d[i], 32'h30 + i);
        end
      end
    end
    total++;
    if (done_n != 1 || pkt_count !== 16'd5) begin
      bad++;
      $display("FAIL busy_ign_done: got done=%0d cnt=%0d want 1 5", done_n, pkt_count);
    end
  endtask

  task automatic test_reset_mid();
    clear_cap();
    ax.tready = 1'b1;
    kick(6, 32'h40);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (ax.tvalid !== 1'b0 || pkt_count !== '0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_state: got v=%b cnt=%0d busy=%b want 0 0 0", ax.tvalid, pkt_count, busy);
    end
    wait_cyc(8);
    total++;
    if (cap_d.size() != 2 || done_n != 0 || cap_l[0] !== 1'b0 || cap_l[1] !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_abandon: got beats=%0d done=%0d want 2 0 no tlast", cap_d.size(), done_n);
    end
    clear_cap();
    kick(2, 32'h7);
    wait_cyc(4);
    total++;
    if (cap_d.size() != 2 || cap_d[0] !== 32'h7 || cap_d[1] !== 32'h8 || cap_l[1] !== 1'b1 || pkt_count !== 16'd1) begin
      bad++;
      $display("FAIL rstmid_restart: got beats=%0d cnt=%0d want 2 beats 7,8 cnt 1", cap_d.size(), pkt_count);
    end
  endtask

  task automatic test_back_to_back();
`ifdef AXIS_PKT_GAP_EN
    localparam int HOLD = GAPC + 4;
    localparam int EXP_SP = GAPC + 2;
`else
    localparam int HOLD = 4;
    localparam int EXP_SP = 2;
`endif
    clear_cap();
    ax.tready = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; start_len = 8'd2; seed = 32'h0;
    repeat (HOLD - 1) @(posedge clk);
    #1 seed = 32'h20;
    @(posedge clk); #1;
    start = 1'b0;
    wait_cyc(6 + GAPC);
    total++;
    if (cap_d.size() != 4) begin
      bad++;
      $display("FAIL b2b_count: got %0d beats want 4", cap_d.size());
    end else begin
      total++;
      if (cap_d[0] !== 32'h0 || cap_d[1] !== 32'h1 || cap_d[2] !== 32'h20 || cap_d[3] !== 32'h21) begin
        bad++;
        $display("FAIL b2b_data: got %h %h %h %h want 0 1 20 21", cap_d[0], cap_d[1], cap_d[2], cap_d[3]);
      end
      total++;
      if (cap_c[2] - cap_c[1] != EXP_SP) begin
        bad++;
        $display("FAIL b2b_spacing: got %0d want %0d", cap_c[2] - cap_c[1], EXP_SP);
      end
      total++;
      if (done_c != cap_c[3] + EXP_SP - 1) begin
        bad++;
        $display("FAIL b2b_done_time: got offset %0d want %0d", done_c - cap_c[3], EXP_SP - 1);
      end
    end
    total++;
    if (done_n != 2 || pkt_count !== 16'd3) begin
      bad++;
      $display("FAIL b2b_done: got done=%0d cnt=%0d want 2 3", done_n, pkt_count);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_ignore();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
